// File: rtl/out_reg_pkg.sv
// -----------------------------------------------------------------------------
// out_reg_pkg
// Shared definitions for the output register bank: lane-mode encodings,
// default geometry and a helper that locates a lane inside a packed word.
// -----------------------------------------------------------------------------
package out_reg_pkg;

    // Lane processing mode, sampled on every accepted write.
    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_RELU = 1'b1;

    // Default geometry.
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_DEPTH      = 4;

    // Lane k of a packed multi-lane word starts at bit k*width.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/out_reg_lane.sv
// -----------------------------------------------------------------------------
// out_reg_lane
// Combinational processing of one signed lane word on its way into the buffer.
// In ReLU mode a negative word (MSB set) is replaced by zero; otherwise the
// word passes unchanged. No widening, no saturation.
//
// Ports:
//   mode_i  : MODE_PASS / MODE_RELU
//   data_i  : raw lane word (two's complement)
//   data_o  : processed lane word
// -----------------------------------------------------------------------------
module out_reg_lane
    import out_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    assign data_o = ((mode_i == MODE_RELU) && data_i[DATA_WIDTH-1]) ? '0 : data_i;

endmodule

// File: rtl/out_reg_bank.sv
// -----------------------------------------------------------------------------
// out_reg_bank
// DEPTH-entry buffer of CHANNELS-lane result words between the accumulation
// stage and a possibly stalling consumer. Writes pass through per-lane ReLU /
// pass-through processing; the head drains through a valid/ready handshake.
// When empty, the output shows the most recently popped entry (hold register).
//
// Ports:
//   OUT_REG_BANK_Clk         : clock, rising edge
//   OUT_REG_BANK_Reset       : asynchronous active-high reset
//   OUT_REG_BANK_Clear       : synchronous flush of entries and Overflow
//   OUT_REG_BANK_Mode        : lane mode for the write (0 pass, 1 ReLU)
//   OUT_REG_BANK_Set         : write request
//   OUT_REG_BANK_Input_Data  : CHANNELS packed lane words, lane 0 in the LSBs
//   OUT_REG_BANK_In_Ready    : a write would be accepted this cycle
//   OUT_REG_BANK_Output_Data : head entry, or hold register when empty
//   OUT_REG_BANK_Out_Valid   : head entry present
//   OUT_REG_BANK_Out_Ready   : consumer takes the head
//   OUT_REG_BANK_Count       : occupancy 0..DEPTH
//   OUT_REG_BANK_Overflow    : sticky, set by a write attempt while full
// -----------------------------------------------------------------------------
module out_reg_bank
    import out_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                         OUT_REG_BANK_Clk,
    input  logic                         OUT_REG_BANK_Reset,
    input  logic                         OUT_REG_BANK_Clear,
    input  logic                         OUT_REG_BANK_Mode,
    input  logic                         OUT_REG_BANK_Set,
    input  logic [CHANNELS*DATA_WIDTH-1:0] OUT_REG_BANK_Input_Data,
    output logic                         OUT_REG_BANK_In_Ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] OUT_REG_BANK_Output_Data,
    output logic                         OUT_REG_BANK_Out_Valid,
    input  logic                         OUT_REG_BANK_Out_Ready,
    output logic [CNT_WIDTH-1:0]         OUT_REG_BANK_Count,
    output logic                         OUT_REG_BANK_Overflow
);

    localparam int                   WORD_W   = CHANNELS * DATA_WIDTH;
    localparam int                   PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);

    logic [WORD_W-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [WORD_W-1:0]    hold_q, hold_d;
    logic [WORD_W-1:0]    lane_data;
    logic                 push;
    logic                 pop;

    // Per-lane ReLU / pass-through on the incoming word.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        out_reg_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .mode_i (OUT_REG_BANK_Mode),
            .data_i (OUT_REG_BANK_Input_Data[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH]),
            .data_o (lane_data[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    // Handshake flags come from registered state only, so In_Ready never
    // waits on Out_Ready: a full buffer refuses a write even if it pops.
    assign OUT_REG_BANK_In_Ready  = (count_q != FULL_CNT);
    assign OUT_REG_BANK_Out_Valid = (count_q != '0);
    assign push = OUT_REG_BANK_Set & OUT_REG_BANK_In_Ready;
    assign pop  = OUT_REG_BANK_Out_Valid & OUT_REG_BANK_Out_Ready;

    assign OUT_REG_BANK_Output_Data = OUT_REG_BANK_Out_Valid ? mem_q[rd_ptr_q] : hold_q;
    assign OUT_REG_BANK_Count       = count_q;
    assign OUT_REG_BANK_Overflow    = overflow_q;

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path leaves one
        // unassigned and no latch is inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        hold_d     = hold_q;

        if (OUT_REG_BANK_Clear) begin
            // Flush wins over push and pop; the hold register survives.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                hold_d   = mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            if (OUT_REG_BANK_Set && !OUT_REG_BANK_In_Ready) begin
                overflow_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge OUT_REG_BANK_Clk or posedge OUT_REG_BANK_Reset) begin
        if (OUT_REG_BANK_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            hold_q     <= hold_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only observable after
    // a push has written them, so resetting them would add logic for nothing.
    always_ff @(posedge OUT_REG_BANK_Clk) begin
        if (push && !OUT_REG_BANK_Clear) begin
            mem_q[wr_ptr_q] <= lane_data;
        end
    end

endmodule

// File: tb/tb_out_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_out_reg_bank
// Self-checking bench for out_reg_bank (16-bit lanes, 4 channels, depth 4).
// A queue-based reference model tracks entries, hold value and Overflow; one
// compare process checks every DUT output against it on each falling edge.
// Directed phases pin the model with literal expectations, then a random
// phase exercises mixed push/pop/clear traffic.
// -----------------------------------------------------------------------------
module tb_out_reg_bank;

    localparam int DW    = 16;
    localparam int CH    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int WW    = DW * CH;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          clr  = 1'b0;
    logic          mode = 1'b0;
    logic          set  = 1'b0;
    logic          ordy = 1'b0;
    logic [WW-1:0] din  = '0;
    logic [WW-1:0] dout;
    logic          in_ready;
    logic          out_valid;
    logic          ovf;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    always #5 clk = ~clk;

    out_reg_bank #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .OUT_REG_BANK_Clk         (clk),
        .OUT_REG_BANK_Reset       (rst),
        .OUT_REG_BANK_Clear       (clr),
        .OUT_REG_BANK_Mode        (mode),
        .OUT_REG_BANK_Set         (set),
        .OUT_REG_BANK_Input_Data  (din),
        .OUT_REG_BANK_In_Ready    (in_ready),
        .OUT_REG_BANK_Output_Data (dout),
        .OUT_REG_BANK_Out_Valid   (out_valid),
        .OUT_REG_BANK_Out_Ready   (ordy),
        .OUT_REG_BANK_Count       (count),
        .OUT_REG_BANK_Overflow    (ovf)
    );

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [WW-1:0] mq[$];
    logic [WW-1:0] m_hold;
    bit            m_ovf;
    bit            m_full;

    function automatic logic [WW-1:0] relu(input logic [WW-1:0] d, input logic m);
        logic [WW-1:0]        r;
        logic signed [DW-1:0] v;
        r = d;
        for (int i = 0; i < CH; i++) begin
            v = d[i*DW +: DW];
            if (m && v < 0) r[i*DW +: DW] = '0;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_hold = '0;
            m_ovf  = 1'b0;
        end else if (clr) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            m_full = (mq.size() == DEPTH);
            if (set && m_full) m_ovf = 1'b1;
            if (ordy && mq.size() != 0) m_hold = mq.pop_front();
            if (set && !m_full) mq.push_back(relu(din, mode));
        end
    end

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            check("cmp_data",     dout,      (mq.size() != 0) ? mq[0] : m_hold);
            check("cmp_valid",    out_valid, WW'(mq.size() != 0));
            check("cmp_in_ready", in_ready,  WW'(mq.size() != DEPTH));
            check("cmp_count",    count,     WW'(mq.size()));
            check("cmp_overflow", ovf,       WW'(m_ovf));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [WW-1:0] rep(input int k);
        logic [DW-1:0] v;
        v = k[DW-1:0];
        return {v, v, v, v};
    endfunction

    // Drive one cycle's inputs, then step past the next rising edge.
    task automatic cycle(input logic s, input logic [WW-1:0] d, input logic m,
                         input logic o, input logic c);
        set  = s;
        din  = d;
        mode = m;
        ordy = o;
        clr  = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_cmp = 1'b1;

        // Mid-cycle asynchronous reset with a live entry and a non-zero hold.
        cycle(1'b1, rep(9),  1'b0, 1'b0, 1'b0);
        cycle(1'b1, rep(10), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0,      1'b0, 1'b1, 1'b0);
        set  = 1'b0;
        ordy = 1'b0;
        check("pre_rst_data", dout, rep(10));
        #3 rst = 1'b1;
        #1;
        check("rst_data",     dout,      '0);
        check("rst_count",    count,     '0);
        check("rst_valid",    out_valid, '0);
        check("rst_in_ready", in_ready,  WW'(1));
        check("rst_overflow", ovf,       '0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill to full, then one more write sets Overflow and is dropped.
        for (int k = 1; k <= 4; k++) cycle(1'b1, rep(k), 1'b0, 1'b0, 1'b0);
        check("fill_count",    count,    WW'(4));
        check("fill_in_ready", in_ready, '0);
        cycle(1'b1, rep(5), 1'b0, 1'b0, 1'b0);
        check("ovf_flag",  ovf,   WW'(1));
        check("ovf_count", count, WW'(4));

        // Drain in order, then the last popped entry is held.
        for (int k = 1; k <= 4; k++) begin
            check("drain_head", dout, rep(k));
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        check("drain_valid", out_valid, '0);
        check("drain_hold",  dout,      rep(4));
        check("drain_count", count,     '0);

        // ReLU versus pass-through on the same lanes {-5, 7, 0x8000, 0x7FFF}.
        cycle(1'b1, 64'h7FFF_8000_0007_FFFB, 1'b1, 1'b0, 1'b0);
        check("relu_data", dout, 64'h7FFF_0000_0007_0000);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 64'h7FFF_8000_0007_FFFB, 1'b0, 1'b0, 1'b0);
        check("pass_data", dout, 64'h7FFF_8000_0007_FFFB);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Concurrent push/pop at Count=2 across pointer wrap.
        cycle(1'b1, rep(16'h100), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, rep(16'h101), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, rep(16'h200 + k), 1'b0, 1'b1, 1'b0);
            check("conc_count", count, WW'(2));
        end
        check("conc_head", dout, rep(16'h204));

        // Clear with Set and Out_Ready at Count=3 and Overflow still set.
        cycle(1'b1, rep(16'h300), 1'b0, 1'b0, 1'b0);
        check("pre_clr_count", count, WW'(3));
        check("pre_clr_ovf",   ovf,   WW'(1));
        cycle(1'b1, rep(16'h301), 1'b0, 1'b1, 1'b1);
        check("clr_count",    count,     '0);
        check("clr_overflow", ovf,       '0);
        check("clr_valid",    out_valid, '0);
        check("clr_hold",     dout,      rep(16'h203));
        check("clr_in_ready", in_ready,  WW'(1));

        // Random traffic: write-heavy first half, read-heavy second half.
        for (int i = 0; i < 600; i++) begin
            logic s, o, c, m;
            logic [WW-1:0] d;
            s = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) < 2);
            o = (i < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) != 0);
            c = ($urandom_range(0, 39) == 0);
            m = $urandom_range(0, 1) == 1;
            d = {$urandom, $urandom};
            cycle(s, d, m, o, c);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
